proc_run_ctrl: RTL and testbench

- Sequencer for processor Z. Takes a host instruction stream over a valid/ready handshake and writes it word-by-word into the instruction RAM through the processor's addr/wEn/wDat port.
- It then asserts working for exactly program length plus DRAIN_CYCLES cycles, and reports done.
- Sits between the host/testbench and the processor. It is the only driver of the processor's addr, wEn, wDat and working inputs.

---
 rtl/proc_run_ctrl_if.sv | 24 ++
 rtl/proc_run_ctrl.sv | 125 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_run_ctrl_if.sv
// Host load stream plus processor instruction-RAM/run port of proc_run_ctrl.
// master = host side (drives the load stream), slave = controller side.
interface proc_run_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic [ADDR_W-1:0] p_addr;
  logic              p_wEn;
  logic [31:0]       p_wDat;
  logic              p_working;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, p_addr, p_wEn, p_wDat, p_working
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, p_addr, p_wEn, p_wDat, p_working
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// Loads a host program into processor Z's instruction RAM, then runs it for prog_len+DRAIN_CYCLES.
// Optional single-step control is enabled by defining PROC_RUN_STEP_EN.
module proc_run_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DEPTH        = 512,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef PROC_RUN_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  proc_run_ctrl_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              ovf
);

  localparam int RUN_W = $clog2(DEPTH + DRAIN_CYCLES + 1);
  localparam logic [ADDR_W:0]  LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [RUN_W-1:0] RUN_DRAIN = RUN_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   prog_len_reg;
  logic              ovf_reg;
  logic [RUN_W-1:0]  run_cnt_reg;
  logic              wen_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdat_reg;

  logic              xfer;
  logic              last_word;
  logic              work_en;
  logic              working;
  logic              run_expire;
  logic              start_ok;
  logic [RUN_W-1:0]  run_last;

`ifdef PROC_RUN_STEP_EN
  logic step_reg;

  // Each step pulse buys exactly one working cycle, one clock later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_reg <= 1'b0;
    else       step_reg <= step & ~abort;
  end

  assign work_en = step_mode ? step_reg : 1'b1;
`else
  assign work_en = 1'b1;
`endif

  assign xfer       = (state_reg == LOAD) && bus.ld_valid;
  assign last_word  = (count_reg == LAST_IDX);
  assign working    = (state_reg == RUN) && work_en;
  assign run_last   = RUN_W'(prog_len_reg) + RUN_DRAIN - RUN_W'(1);
  assign run_expire = working && (run_cnt_reg == run_last);
  assign start_ok   = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: if (start) state_next = LOAD;
        // Word DEPTH-1 closes the program even without ld_last.
        LOAD:       if (xfer && (bus.ld_last || last_word)) state_next = FLUSH;
        FLUSH:      state_next = RUN;
        RUN:        if (run_expire) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      prog_len_reg <= '0;
      ovf_reg      <= 1'b0;
      run_cnt_reg  <= '0;
      wen_reg      <= 1'b0;
      addr_reg     <= '0;
      wdat_reg     <= '0;
    end else begin
      state_reg <= state_next;
      // A transfer coinciding with abort is dropped entirely.
      wen_reg   <= xfer && !abort;
      if (xfer && !abort) begin
        addr_reg     <= count_reg[ADDR_W-1:0];
        wdat_reg     <= bus.ld_data;
        count_reg    <= count_reg + 1'b1;
        prog_len_reg <= count_reg + 1'b1;
        if (last_word && !bus.ld_last) ovf_reg <= 1'b1;
      end
      if (start_ok && !abort) begin
        count_reg    <= '0;
        prog_len_reg <= '0;
        ovf_reg      <= 1'b0;
      end
      if (state_reg == FLUSH)  run_cnt_reg <= '0;
      else if (working)        run_cnt_reg <= run_cnt_reg + 1'b1;
    end
  end

  assign bus.ld_ready  = (state_reg == LOAD);
  assign bus.p_wEn     = wen_reg;
  assign bus.p_addr    = addr_reg;
  assign bus.p_wDat    = wdat_reg;
  assign bus.p_working = working;

  assign busy     = (state_reg != IDLE) && (state_reg != DONE);
  assign done     = (state_reg == DONE);
  assign prog_len = prog_len_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed self-checking bench for proc_run_ctrl (small DEPTH so overflow is reachable).
module tb_proc_run_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;
  localparam int DRAIN  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
`ifdef PROC_RUN_STEP_EN
  logic step_mode = 1'b0;
  logic step      = 1'b0;
`endif
  logic            busy, done, ovf;
  logic [ADDR_W:0] prog_len;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] words [8];

  proc_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  proc_run_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
`ifdef PROC_RUN_STEP_EN
    .step_mode(step_mode),
    .step     (step),
`endif
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .prog_len (prog_len),
    .ovf      (ovf)
  );

  always #5 clock = ~clock;

  // Cycle monitor, sampled 1 time unit after each rising edge.
  int cyc = 0, wen_n = 0, work_n = 0, rise_n = 0, overlap_n = 0;
  int last_wen_cyc = 0, rise_cyc = 0;
  logic prev_work = 1'b0;
  logic [ADDR_W-1:0] wa [64];
  logic [31:0]       wd [64];

  always @(posedge clock) begin
    #1;
    cyc       <= cyc + 1;
    prev_work <= bus.p_working;
    if (bus.p_wEn === 1'b1) begin
      if (wen_n < 64) begin
        wa[wen_n] <= bus.p_addr;
        wd[wen_n] <= bus.p_wDat;
      end
      wen_n        <= wen_n + 1;
      last_wen_cyc <= cyc;
    end
    if (bus.p_working === 1'b1) work_n <= work_n + 1;
    if (bus.p_working === 1'b1 && prev_work !== 1'b1) begin
      rise_n   <= rise_n + 1;
      rise_cyc <= cyc;
    end
    if (bus.p_working === 1'b1 && bus.p_wEn === 1'b1) overlap_n <= overlap_n + 1;
  end

  task automatic pulse_start;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sends n words from words[], each preceded by gap idle cycles; returns at the FLUSH negedge.
  task automatic drive_words(input int n, input int gap, input bit mark_last);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) @(negedge clock);
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = mark_last && (i == n - 1);
      @(negedge clock);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
    end
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL rst_ready: got %0b want 0", bus.ld_ready); else n_pass++;
    n_checks++; if (bus.p_wEn !== 1'b0) $display("FAIL rst_wen: got %0b want 0", bus.p_wEn); else n_pass++;
    n_checks++; if (bus.p_working !== 1'b0) $display("FAIL rst_working: got %0b want 0", bus.p_working); else n_pass++;
    n_checks++; if (bus.p_addr !== '0) $display("FAIL rst_addr: got %0h want 0", bus.p_addr); else n_pass++;
    n_checks++; if (bus.p_wDat !== 32'h0) $display("FAIL rst_wdat: got %0h want 0", bus.p_wDat); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done: got %0b%0b want 00", busy, done); else n_pass++;
    n_checks++; if (prog_len !== '0 || ovf !== 1'b0) $display("FAIL rst_len_ovf: got %0d/%0b want 0/0", prog_len, ovf); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("test_reset complete");
  endtask

  task automatic test_back_to_back;
    int w0, k0, r0, o0;
    bit to;
    words[0] = 32'h10010005; words[1] = 32'h10020003; words[2] = 32'h20120000;
    w0 = wen_n; k0 = work_n; r0 = rise_n; o0 = overlap_n;
    pulse_start();
    n_checks++; if (bus.ld_ready !== 1'b1 || busy !== 1'b1) $display("FAIL b2b_load_state: got ready=%0b busy=%0b want 1 1", bus.ld_ready, busy); else n_pass++;
    drive_words(3, 0, 1'b1);
    n_checks++; if (bus.ld_ready !== 1'b0 || bus.p_wEn !== 1'b1 || bus.p_working !== 1'b0)
      $display("FAIL b2b_flush: got ready=%0b wen=%0b work=%0b want 0 1 0", bus.ld_ready, bus.p_wEn, bus.p_working); else n_pass++;
    wait_done(to);
    n_checks++; if (to) $display("FAIL b2b_timeout: got no done want done within 60 cycles"); else n_pass++;
    n_checks++; if (wen_n - w0 !== 3) $display("FAIL b2b_wen_count: got %0d want 3", wen_n - w0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wa[w0+i] !== ADDR_W'(i) || wd[w0+i] !== words[i])
        $display("FAIL b2b_write%0d: got %0h:%08h want %0h:%08h", i, wa[w0+i], wd[w0+i], i, words[i]); else n_pass++;
    end
    n_checks++; if (work_n - k0 !== 6 || rise_n - r0 !== 1) $display("FAIL b2b_working: got %0d cycles in %0d bursts want 6 in 1", work_n - k0, rise_n - r0); else n_pass++;
    n_checks++; if (rise_cyc - last_wen_cyc !== 1) $display("FAIL b2b_flush_gap: got %0d want 1", rise_cyc - last_wen_cyc); else n_pass++;
    n_checks++; if (overlap_n - o0 !== 0) $display("FAIL b2b_overlap: got %0d want 0", overlap_n - o0); else n_pass++;
    n_checks++; if (prog_len !== 5'd3 || ovf !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_status: got len=%0d ovf=%0b busy=%0b want 3 0 0", prog_len, ovf, busy); else n_pass++;
    n_checks++; if (bus.p_addr !== ADDR_W'(2)) $display("FAIL b2b_addr_hold: got %0d want 2", bus.p_addr); else n_pass++;
    $display("test_back_to_back complete");
  endtask

  task automatic test_gap_load;
    int w0, k0, o0;
    bit to;
    for (int i = 0; i < 4; i++) words[i] = 32'hA5000000 + 32'(i * 17);
    w0 = wen_n; k0 = work_n; o0 = overlap_n;
    pulse_start();
    n_checks++; if (done !== 1'b0) $display("FAIL gap_done_fall: got %0b want 0", done); else n_pass++;
    drive_words(4, 2, 1'b1);
    n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL gap_ready_after_last: got %0b want 0", bus.ld_ready); else n_pass++;
    wait_done(to);
    n_checks++; if (to) $display("FAIL gap_timeout: got no done want done within 60 cycles"); else n_pass++;
    n_checks++; if (wen_n - w0 !== 4) $display("FAIL gap_wen_count: got %0d want 4", wen_n - w0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (wa[w0+i] !== ADDR_W'(i) || wd[w0+i] !== words[i])
        $display("FAIL gap_write%0d: got %0h:%08h want %0h:%08h", i, wa[w0+i], wd[w0+i], i, words[i]); else n_pass++;
    end
    n_checks++; if (work_n - k0 !== 7) $display("FAIL gap_working: got %0d want 7", work_n - k0); else n_pass++;
    n_checks++; if (overlap_n - o0 !== 0) $display("FAIL gap_overlap: got %0d want 0", overlap_n - o0); else n_pass++;
    n_checks++; if (prog_len !== 5'd4) $display("FAIL gap_prog_len: got %0d want 4", prog_len); else n_pass++;
    $display("test_gap_load complete");
  endtask

  task automatic test_overflow;
    int w0, k0;
    bit to;
    for (int i = 0; i < 8; i++) words[i] = 32'hC0DE0000 | 32'(i);
    w0 = wen_n; k0 = work_n;
    pulse_start();
    drive_words(8, 0, 1'b0);
    n_checks++; if (bus.ld_ready !== 1'b0 || ovf !== 1'b1) $display("FAIL ovf_flush: got ready=%0b ovf=%0b want 0 1", bus.ld_ready, ovf); else n_pass++;
    wait_done(to);
    n_checks++; if (to) $display("FAIL ovf_timeout: got no done want done within 60 cycles"); else n_pass++;
    n_checks++; if (wen_n - w0 !== 8 || wa[w0+7] !== ADDR_W'(7)) $display("FAIL ovf_writes: got %0d last addr %0d want 8 last 7", wen_n - w0, wa[w0+7]); else n_pass++;
    n_checks++; if (work_n - k0 !== 11) $display("FAIL ovf_working: got %0d want 11", work_n - k0); else n_pass++;
    n_checks++; if (prog_len !== 5'd8) $display("FAIL ovf_prog_len: got %0d want 8", prog_len); else n_pass++;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++; if (done !== 1'b0 || ovf !== 1'b1 || prog_len !== 5'd8)
      $display("FAIL ovf_abort_keep: got done=%0b ovf=%0b len=%0d want 0 1 8", done, ovf, prog_len); else n_pass++;
    $display("test_overflow complete");
  endtask

  task automatic test_abort_run;
    int w0, k0;
    bit to;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    k0 = work_n;
    pulse_start();
    drive_words(3, 0, 1'b1);
    @(negedge clock);
    n_checks++; if (bus.p_working !== 1'b1) $display("FAIL abort_run_first: got %0b want 1", bus.p_working); else n_pass++;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_checks++; if (bus.p_working !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_run_idle: got work=%0b busy=%0b done=%0b want 0 0 0", bus.p_working, busy, done); else n_pass++;
    n_checks++; if (prog_len !== 5'd3) $display("FAIL abort_run_len: got %0d want 3", prog_len); else n_pass++;
    n_checks++; if (work_n - k0 !== 2) $display("FAIL abort_run_cycles: got %0d want 2", work_n - k0); else n_pass++;
    // abort together with an accepted word: that write must never appear
    w0 = wen_n;
    pulse_start();
    bus.ld_valid = 1'b1; bus.ld_data = 32'hDEADBEEF; abort = 1'b1;
    @(negedge clock);
    bus.ld_valid = 1'b0; abort = 1'b0;
    n_checks++; if (bus.p_wEn !== 1'b0 || bus.ld_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_load_drop: got wen=%0b ready=%0b busy=%0b want 0 0 0", bus.p_wEn, bus.ld_ready, busy); else n_pass++;
    @(negedge clock);
    n_checks++; if (wen_n - w0 !== 0 || prog_len !== 5'd0) $display("FAIL abort_load_count: got %0d writes len=%0d want 0 0", wen_n - w0, prog_len); else n_pass++;
    k0 = work_n;
    words[0] = 32'h0000ABCD;
    pulse_start();
    drive_words(1, 0, 1'b1);
    wait_done(to);
    n_checks++; if (to) $display("FAIL abort_rerun_timeout: got no done want done within 60 cycles"); else n_pass++;
    n_checks++; if (work_n - k0 !== 4 || prog_len !== 5'd1) $display("FAIL abort_rerun: got %0d cycles len=%0d want 4 1", work_n - k0, prog_len); else n_pass++;
    $display("test_abort_run complete");
  endtask

  task automatic test_start_abort;
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.ld_ready !== 1'b0)
      $display("FAIL start_abort_idle: got busy=%0b done=%0b ready=%0b want 0 0 0", busy, done, bus.ld_ready); else n_pass++;
    @(negedge clock);
    n_checks++; if (bus.ld_ready !== 1'b0 || prog_len !== 5'd1) $display("FAIL start_abort_hold: got ready=%0b len=%0d want 0 1", bus.ld_ready, prog_len); else n_pass++;
    $display("test_start_abort complete");
  endtask

  task automatic test_async_reset;
    words[0] = 32'h5A5A5A5A; words[1] = 32'hA5A5A5A5;
    pulse_start();
    bus.ld_valid = 1'b1; bus.ld_data = words[0];
    @(negedge clock);
    bus.ld_data = words[1];
    n_checks++; if (bus.p_wEn !== 1'b1 || prog_len !== 5'd1 || busy !== 1'b1)
      $display("FAIL async_pre: got wen=%0b len=%0d busy=%0b want 1 1 1", bus.p_wEn, prog_len, busy); else n_pass++;
    #1 reset = 1'b1;
    bus.ld_valid = 1'b0;
    #1;
    n_checks++; if (bus.p_wEn !== 1'b0 || bus.ld_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_ctrl: got wen=%0b ready=%0b busy=%0b want 0 0 0", bus.p_wEn, bus.ld_ready, busy); else n_pass++;
    n_checks++; if (prog_len !== '0 || bus.p_wDat !== 32'h0 || bus.p_addr !== '0)
      $display("FAIL async_data: got len=%0d wdat=%08h addr=%0d want 0 0 0", prog_len, bus.p_wDat, bus.p_addr); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("test_async_reset complete");
  endtask

`ifdef PROC_RUN_STEP_EN
  task automatic test_step;
    int k0, r0;
    words[0] = 32'h10010005; words[1] = 32'h10020003;
    step_mode = 1'b1;
    k0 = work_n; r0 = rise_n;
    pulse_start();
    drive_words(2, 0, 1'b1);
    repeat (4) @(negedge clock);
    n_checks++; if (work_n - k0 !== 0 || busy !== 1'b1) $display("FAIL step_hold: got %0d cycles busy=%0b want 0 1", work_n - k0, busy); else n_pass++;
    for (int s = 0; s < 5; s++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      n_checks++; if (bus.p_working !== 1'b1) $display("FAIL step_pulse%0d: got %0b want 1", s, bus.p_working); else n_pass++;
      @(negedge clock);
      n_checks++; if (bus.p_working !== 1'b0) $display("FAIL step_gap%0d: got %0b want 0", s, bus.p_working); else n_pass++;
    end
    n_checks++; if (done !== 1'b1 || work_n - k0 !== 5 || rise_n - r0 !== 5)
      $display("FAIL step_done: got done=%0b cycles=%0d bursts=%0d want 1 5 5", done, work_n - k0, rise_n - r0); else n_pass++;
    step_mode = 1'b0;
    $display("test_step complete");
  endtask
`endif

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;
    bus.ld_last  = 1'b0;
    test_reset();
    test_back_to_back();
    test_gap_load();
    test_overflow();
    test_abort_run();
    test_start_abort();
    test_async_reset();
`ifdef PROC_RUN_STEP_EN
    test_step();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
